hazard_detect: RTL

HAZARD_DETECT -- requirements
Module: hazard_detect

---
 rtl/hazard_detect_pkg.sv | 38 +++
 rtl/hazard_match.sv | 31 +++
 rtl/hazard_detect.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hazard_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect_pkg
// Description : Shared pipeline definitions: control FSM states, forwarding
//               select encodings and the in-flight scoreboard entry record.
// Ports       : (package, none)
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_detect_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  // Pipeline control FSM.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Operand source selects used by the forwarding unit.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // register file
    FWD_WB  = 2'b01,  // MEM/WB result
    FWD_MEM = 2'b10   // EX/MEM result
  } fwd_sel_e;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_match
// Description : Compares one ID source operand with one scoreboard entry.
//               A match needs the operand to be really read, the entry to be
//               a live register write, equal register numbers, and a
//               destination other than $0 (which is never written).
// Ports       : src_use_i          - ID instruction valid and reads this source
//               src_reg_i          - source register number
//               entry_valid_i      - entry holds a real instruction
//               entry_rd_i         - entry destination register
//               entry_reg_write_i  - entry writes the register file
//               match_o            - dependence detected
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_match
  import hazard_detect_pkg::*;
(
  input  logic             src_use_i,
  input  logic [REG_W-1:0] src_reg_i,
  input  logic             entry_valid_i,
  input  logic [REG_W-1:0] entry_rd_i,
  input  logic             entry_reg_write_i,
  output logic             match_o
);

  assign match_o = src_use_i & entry_valid_i & entry_reg_write_i
                 & (src_reg_i == entry_rd_i) & (src_reg_i != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Pipeline hazard detection unit. Tracks the instructions in EX
//               and MEM in a two-entry scoreboard and stalls ID on load-use
//               dependences and on branches (resolved in ID) whose operands
//               are not yet available. Counts stall cycles (saturating).
// Ports       : clk_i, rst_i (async, active-high), start_i (pipeline enable)
//               ID_*_i             - decoded fields of the instruction in ID
//               pc_write_o         - PC load enable
//               if_id_write_o      - IF/ID load enable
//               id_ex_bubble_o     - force zero control into ID/EX
//               if_id_flush_o      - squash IF/ID on a taken branch
//               stall_cnt_o        - stall cycles since reset
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
  import hazard_detect_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             ID_valid_i,
  input  logic [REG_W-1:0] ID_rs_i,
  input  logic [REG_W-1:0] ID_rt_i,
  input  logic             ID_use_rs_i,
  input  logic             ID_use_rt_i,
  input  logic [REG_W-1:0] ID_rd_i,
  input  logic             ID_RegWrite_i,
  input  logic             ID_MemRead_i,
  input  logic             ID_branch_i,
  input  logic             ID_branch_taken_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             id_ex_bubble_o,
  output logic             if_id_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  state_e           state_q, state_d;
  sb_entry_t        ex_q, ex_d;
  sb_entry_t        mem_q, mem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic m_rs_ex, m_rt_ex, m_rs_mem, m_rt_mem;
  logic load_use_stall, branch_stall, stall;

  hazard_match u_match_rs_ex (
    .src_use_i        (ID_valid_i & ID_use_rs_i),
    .src_reg_i        (ID_rs_i),
    .entry_valid_i    (ex_q.valid),
    .entry_rd_i       (ex_q.rd),
    .entry_reg_write_i(ex_q.reg_write),
    .match_o          (m_rs_ex)
  );

  hazard_match u_match_rt_ex (
    .src_use_i        (ID_valid_i & ID_use_rt_i),
    .src_reg_i        (ID_rt_i),
    .entry_valid_i    (ex_q.valid),
    .entry_rd_i       (ex_q.rd),
    .entry_reg_write_i(ex_q.reg_write),
    .match_o          (m_rt_ex)
  );

  hazard_match u_match_rs_mem (
    .src_use_i        (ID_valid_i & ID_use_rs_i),
    .src_reg_i        (ID_rs_i),
    .entry_valid_i    (mem_q.valid),
    .entry_rd_i       (mem_q.rd),
    .entry_reg_write_i(mem_q.reg_write),
    .match_o          (m_rs_mem)
  );

  hazard_match u_match_rt_mem (
    .src_use_i        (ID_valid_i & ID_use_rt_i),
    .src_reg_i        (ID_rt_i),
    .entry_valid_i    (mem_q.valid),
    .entry_rd_i       (mem_q.rd),
    .entry_reg_write_i(mem_q.reg_write),
    .match_o          (m_rt_mem)
  );

  // ALU consumers get a forwarded EX/MEM value, so only a load in EX hurts.
  // A branch compares in ID, so it must wait for any producer in EX and for
  // a load that is still in MEM.
  assign load_use_stall = (m_rs_ex | m_rt_ex) & ex_q.mem_read;
  assign branch_stall   = ID_branch_i
                        & ((m_rs_ex | m_rt_ex) | ((m_rs_mem | m_rt_mem) & mem_q.mem_read));
  assign stall          = load_use_stall | branch_stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ex_q        <= SB_EMPTY;
      mem_q       <= SB_EMPTY;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ex_d           = ex_q;
    mem_d          = mem_q;
    stall_cnt_d    = stall_cnt_q;
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    id_ex_bubble_o = 1'b1;
    if_id_flush_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ex_d  = SB_EMPTY;
        mem_d = SB_EMPTY;
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        mem_d = ex_q;
        if (stall) begin
          // Held instruction stays in ID; a bubble goes down the pipe.
          ex_d = SB_EMPTY;
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
          ex_d           = '{valid: ID_valid_i, rd: ID_rd_i,
                             reg_write: ID_RegWrite_i, mem_read: ID_MemRead_i};
          pc_write_o     = 1'b1;
          if_id_write_o  = 1'b1;
          id_ex_bubble_o = 1'b0;
          if_id_flush_o  = ID_valid_i & ID_branch_i & ID_branch_taken_i;
        end
        if (!start_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire
